// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the main memory responder
package mem_pkg;

    localparam int DEF_LATENCY = 4;
    localparam int DEF_WORDS   = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte 0 is the most significant byte when viewed as a 32-bit vector.
    typedef logic [0:3][7:0] word_bytes_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word storage with synchronous write and registered read
module mem_array
    import mem_pkg::*;
#(
    parameter  int WORDS = DEF_WORDS,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  word_bytes_t      wdata_i,
    output word_bytes_t      rdata_o
);

    // Storage is deliberately left out of reset so contents survive it.
    word_bytes_t mem_q [WORDS];
    word_bytes_t rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - fixed-latency memory responder: FSM, latency counter and storage
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  word_bytes_t mem_data_in,
    output word_bytes_t mem_data_out,
    output logic        mem_ready,
    output logic        mem_busy
);

    localparam int IDX_W = $clog2(WORDS);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic               we_q;
    word_bytes_t        wdata_q;
    logic               accept;
    logic               fire;
    logic               unused_addr;

    assign unused_addr = ^{mem_addr[31:IDX_W+2], mem_addr[1:0]};

    assign accept = (state_q == IDLE) && mem_req;
    assign fire   = (state_q == BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_req) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state_q == DONE);
        mem_busy  = (state_q != IDLE);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 4'(LATENCY - 1);
        end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Request fields are captured only on acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                idx_q   <= mem_addr[IDX_W+1:2];
                we_q    <= mem_we;
                wdata_q <= mem_data_in;
            end
        end
    end

    mem_array #(
        .WORDS (WORDS)
    ) u_mem_array (
        .clk     (clk),
        .rst_b   (rst_b),
        .wr_en_i (fire && we_q),
        .rd_en_i (fire && !we_q),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_data_out)
    );

endmodule
